// File: rtl/reg_sipo_rx.sv
// reg_sipo_rx -- serial-in / parallel-out receiver with a holding register.
//
// Bits presented on serial_in are sampled whenever enable & bit_valid is high
// at a rising clk edge and shifted into an assembly register. The WIDTH-th
// sample completes the word, which is moved (same edge) into a separate
// holding register exposed as data_out/data_valid with a valid/ack handshake.
// A word completing while the holding register is still full is dropped and
// flags the sticky overrun bit.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   enable     global enable; bit_valid ignored when low
//   serial_in  serial data bit
//   bit_valid  sample serial_in this edge (when enable=1)
//   clear      abort partial word and clear overrun
//   data_ack   consumer accepts data_out (only while data_valid=1)
//   data_out   last completed word
//   data_valid data_out holds an unread word
//   overrun    sticky: a completed word was dropped
//   busy       partial word in progress
//   bit_count  bits received in the current word (0..WIDTH-1)
module reg_sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             clear,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             busy,
  output logic [CW-1:0]    bit_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             sample;
  logic             completing;
  logic             hold_free;

  // Word after this edge's shift; on the completing sample this is the full
  // word including the final bit, so it loads with zero added latency.
  if (LSB_FIRST) begin : g_lsb
    assign shifted = {serial_in, sreg[WIDTH-1:1]};
  end else begin : g_msb
    assign shifted = {sreg[WIDTH-2:0], serial_in};
  end

  assign sample     = enable & bit_valid;
  // clear wins over sample, so a clear cycle never completes a word.
  assign completing = sample & ~clear & (state == SHIFT) & (bit_count == LAST);
  assign hold_free  = ~data_valid | data_ack;
  assign busy       = (bit_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Holding register: a load on the ack edge keeps data_valid high.
      if (completing && hold_free) begin
        data_out   <= shifted;
        data_valid <= 1'b1;
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
      end

      if (clear) begin
        state     <= IDLE;
        sreg      <= '0;
        bit_count <= '0;
        overrun   <= 1'b0;
      end else if (sample) begin
        sreg <= shifted;
        case (state)
          IDLE: begin
            state     <= SHIFT;
            bit_count <= CW'(1);
          end
          SHIFT: begin
            if (bit_count == LAST) begin
              state     <= IDLE;
              bit_count <= '0;
              if (!hold_free) overrun <= 1'b1;
            end else begin
              bit_count <= bit_count + CW'(1);
            end
          end
          default: begin
            state     <= IDLE;
            bit_count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_sipo_rx.sv
// Bench for reg_sipo_rx: u0 is WIDTH=4 LSB-first, u1 is WIDTH=4 MSB-first.
// Words expected on u0 are queued by the stimulus; a monitor pops and
// compares each time u0 loads a new word into its holding register.
module tb_reg_sipo_rx;

  logic       clk = 1'b0;
  logic       reset, enable, en1, serial_in, bit_valid, clear, data_ack;
  logic [3:0] data_out0, data_out1;
  logic       data_valid0, data_valid1, overrun0, overrun1, busy0, busy1;
  logic [2:0] bit_count0, bit_count1;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  reg_sipo_rx #(.WIDTH(4), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .serial_in(serial_in),
    .bit_valid(bit_valid), .clear(clear), .data_ack(data_ack),
    .data_out(data_out0), .data_valid(data_valid0), .overrun(overrun0),
    .busy(busy0), .bit_count(bit_count0));

  reg_sipo_rx #(.WIDTH(4), .LSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset(reset), .enable(en1), .serial_in(serial_in),
    .bit_valid(bit_valid), .clear(clear), .data_ack(data_ack),
    .data_out(data_out1), .data_valid(data_valid1), .overrun(overrun1),
    .busy(busy1), .bit_count(bit_count1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: a new word is present when data_valid is high now and, at the
  // previous sampling point, either nothing was held or an ack was pending.
  logic pv = 1'b0, pa = 1'b0;
  always @(negedge clk) begin
    if (!reset && data_valid0 && (!pv || pa)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got %0h want none", data_out0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (data_out0 !== e) begin
          bad++;
          $display("FAIL mon_word: got %0h want %0h", data_out0, e);
        end
      end
    end
    pv = data_valid0;
    pa = data_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bitq(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) bitq(w[i]);
  endtask

  task automatic ack();
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
  endtask

  initial begin
    logic [3:0] tx;
    // Reset with arbitrary active inputs
    reset = 1'b1; enable = 1'b1; en1 = 1'b1; serial_in = 1'b1;
    bit_valid = 1'b1; clear = 1'b0; data_ack = 1'b1;
    step(); step();
    chk("rst_data_out", data_out0, 4'h0);
    chk("rst_valid", data_valid0, 0);
    chk("rst_overrun", overrun0, 0);
    chk("rst_bit_count", bit_count0, 0);
    chk("rst_busy", busy0, 0);
    reset = 1'b0; en1 = 1'b0; bit_valid = 1'b0; data_ack = 1'b0; serial_in = 1'b0;
    step();

    // Basic receive: bits 1,1,0,1 -> 4'b1011
    exp_q.push_back(4'hB);
    bitq(1'b1);
    chk("basic_busy1", busy0, 1);
    chk("basic_cnt1", bit_count0, 1);
    bitq(1'b1);
    bitq(1'b0);
    chk("basic_busy3", busy0, 1);
    chk("basic_cnt3", bit_count0, 3);
    bitq(1'b1);
    chk("basic_valid", data_valid0, 1);
    chk("basic_data", data_out0, 4'hB);
    chk("basic_idle", busy0, 0);
    ack();
    chk("basic_acked", data_valid0, 0);

    // Loopback from a PISO model: loads 4'hA, shifts Q[0] out first
    tx = 4'hA;
    exp_q.push_back(4'hA);
    for (int i = 0; i < 4; i++) begin
      bitq(tx[0]);
      tx = {1'b0, tx[3:1]};
    end
    chk("loop_data", data_out0, 4'hA);
    ack();

    // Back-to-back with ack on the second completion edge
    exp_q.push_back(4'h3);
    send_word(4'h3);
    chk("b2b_first", data_out0, 4'h3);
    exp_q.push_back(4'hC);
    bitq(1'b0); bitq(1'b0); bitq(1'b1);
    data_ack = 1'b1;
    bitq(1'b1);
    data_ack = 1'b0;
    chk("b2b_data", data_out0, 4'hC);
    chk("b2b_valid", data_valid0, 1);
    chk("b2b_overrun", overrun0, 0);
    ack();

    // Overrun: 5 held, 9 dropped
    exp_q.push_back(4'h5);
    send_word(4'h5);
    send_word(4'h9);
    chk("ovr_data", data_out0, 4'h5);
    chk("ovr_flag", overrun0, 1);
    chk("ovr_cnt", bit_count0, 0);
    clear = 1'b1; step(); clear = 1'b0;
    chk("ovr_cleared", overrun0, 0);
    chk("ovr_valid_kept", data_valid0, 1);
    chk("ovr_data_kept", data_out0, 4'h5);
    ack();

    // Enable gap: bits 0,1 | 3 disabled cycles | 1,1 -> 4'hE
    exp_q.push_back(4'hE);
    bitq(1'b0); bitq(1'b1);
    enable = 1'b0; serial_in = 1'b0; bit_valid = 1'b1;
    step(); step(); step();
    bit_valid = 1'b0; enable = 1'b1;
    chk("gap_cnt", bit_count0, 2);
    bitq(1'b1); bitq(1'b1);
    chk("gap_data", data_out0, 4'hE);
    ack();

    // Clear mid-word (bit in the clear cycle is discarded), then 4'h6
    bitq(1'b1); bitq(1'b1);
    clear = 1'b1; serial_in = 1'b1; bit_valid = 1'b1;
    step();
    clear = 1'b0; bit_valid = 1'b0;
    chk("clr_cnt", bit_count0, 0);
    chk("clr_busy", busy0, 0);
    exp_q.push_back(4'h6);
    send_word(4'h6);
    chk("clr_data", data_out0, 4'h6);
    ack();

    // Reset mid-word
    bitq(1'b1); bitq(1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstmid_cnt", bit_count0, 0);
    step();

    // MSB-first instance: bits 1,0,0,0 -> 4'b1000, then 1,1,0,1 -> 4'hD
    enable = 1'b0; en1 = 1'b1;
    bitq(1'b1); bitq(1'b0); bitq(1'b0); bitq(1'b0);
    chk("msb_valid", data_valid1, 1);
    chk("msb_data", data_out1, 4'h8);
    ack();
    bitq(1'b1); bitq(1'b1); bitq(1'b0); bitq(1'b1);
    chk("msb_data2", data_out1, 4'hD);
    chk("msb_overrun", overrun1, 0);
    chk("lsb_quiet", data_valid0, 0);
    ack();
    en1 = 1'b0;
    step(); step();

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
